// File: rtl/pipeline_trace_tx.sv
// =============================================================================
// pipeline_trace_tx : per-cycle CPU trace capture into a record FIFO,
//                     serialized as a valid/ready byte stream.
// Optional build macro TRACE_SYNC_EN : prefix each record with sync byte 0xA5.
// Revision 1.0 : initial release
// =============================================================================
`default_nettype none

module pipeline_trace_tx #(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] pc_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        tx_ready_i,
   output logic        tx_valid_o,
   output logic [7:0]  tx_data_o,
   output logic [7:0]  drop_cnt_o,
   output logic [15:0] cycle_cnt_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef TRACE_SYNC_EN
   localparam logic [3:0] LAST_IDX = 4'd8;
`else
   localparam logic [3:0] LAST_IDX = 4'd7;
`endif
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [0:0]  r_state, w_state_nxt;
   logic [3:0]  r_idx, w_idx_nxt;
   logic        r_tx_valid, w_tx_valid_nxt;
   logic [7:0]  r_tx_data, w_tx_data_nxt;
   logic [7:0]  r_stall_cnt, r_flush_cnt, r_drop_cnt;
   logic [15:0] r_cycle_cnt;
   logic [63:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_inc;
   logic [AW:0]   r_count, w_count_nxt;

   logic [7:0]  w_stall_nxt, w_flush_nxt;
   logic [63:0] w_rec, w_head, w_next_head;
   logic        w_full, w_pop, w_accept, w_drop;

   function automatic logic [7:0] f_rec_byte(input logic [63:0] rec, input logic [3:0] idx);
      logic [63:0] v_sh;
`ifdef TRACE_SYNC_EN
      if (idx == 4'd0) return 8'hA5;
      v_sh = rec >> {idx - 4'd1, 3'b000};
`else
      v_sh = rec >> {idx, 3'b000};
`endif
      return v_sh[7:0];
   endfunction

   // Record fields carry the counts including this cycle's events.
   assign w_stall_nxt = r_stall_cnt + {7'd0, stall_i};
   assign w_flush_nxt = r_flush_cnt + {7'd0, flush_i};
   assign w_rec       = {r_cycle_cnt, w_flush_nxt, w_stall_nxt, pc_i};

   assign w_full      = (r_count == (AW+1)'(DEPTH));
   assign w_pop       = (r_state == S_SEND) && (r_idx == LAST_IDX) && tx_ready_i;
   assign w_accept    = start_i && (!w_full || w_pop);
   assign w_drop      = start_i && w_full && !w_pop;
   assign w_count_nxt = r_count + (AW+1)'(w_accept) - (AW+1)'(w_pop);

   // After a pop of the only stored record, the next head is the one pushed now.
   assign w_rd_inc    = r_rd_ptr + 1'b1;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_next_head = (r_count > (AW+1)'(1)) ? r_mem[w_rd_inc] : w_rec;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_idx      <= 4'd0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_tx_valid <= w_tx_valid_nxt;
         r_tx_data  <= w_tx_data_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_state_nxt = S_SEND;
               w_idx_nxt   = 4'd0;
            end
         end
         S_SEND: begin
            if (tx_ready_i) begin
               if (r_idx == LAST_IDX) begin
                  w_idx_nxt   = 4'd0;
                  w_state_nxt = (w_count_nxt != '0) ? S_SEND : S_IDLE;
               end else begin
                  w_idx_nxt = r_idx + 4'd1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 4'd0;
         end
      endcase
   end

   always_comb begin
      w_tx_valid_nxt = (w_state_nxt == S_SEND);
      w_tx_data_nxt  = 8'd0;
      if (w_state_nxt == S_SEND) begin
         if (w_pop) w_tx_data_nxt = f_rec_byte(w_next_head, 4'd0);
         else       w_tx_data_nxt = f_rec_byte(w_head, w_idx_nxt);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cycle_cnt <= 16'd0;
         r_stall_cnt <= 8'd0;
         r_flush_cnt <= 8'd0;
         r_drop_cnt  <= 8'd0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
      end else begin
         if (start_i) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
            r_stall_cnt <= w_stall_nxt;
            r_flush_cnt <= w_flush_nxt;
         end
         if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
         if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)    r_rd_ptr <= w_rd_inc;
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_accept) r_mem[r_wr_ptr] <= w_rec;
   end

   assign tx_valid_o  = r_tx_valid;
   assign tx_data_o   = r_tx_data;
   assign drop_cnt_o  = r_drop_cnt;
   assign cycle_cnt_o = r_cycle_cnt;

endmodule

`default_nettype wire
